// File: rtl/prf_pkg.sv
// Shared types and constants for the physical-register release queue.
package prf_pkg;

    localparam int TAG_W = 7;

    // First physical tag handed to the free list after reset; tags below
    // this hold the architectural mappings.
    localparam logic [TAG_W-1:0] RESET_TAG_BASE = TAG_W'(32);

    // Value driven on retire tag outputs that carry no tag this cycle.
    localparam logic [TAG_W-1:0] TAG_NONE = '0;

    typedef struct packed {
        logic             valid;
        logic             done;
        logic             has_dest;
        logic [TAG_W-1:0] old_tag;
    } prq_entry_t;

endpackage

// File: rtl/prf_release_queue_retire_compact.sv
// Packs the tags of up to two retiring entries into the free-list outputs,
// skipping entries that wrote no destination register.
module prq_retire_compact
    import prf_pkg::*;
#(
    parameter int TAG_W = prf_pkg::TAG_W
) (
    input  logic             r0_i,
    input  logic             r1_i,
    input  logic             has_dest_0_i,
    input  logic [TAG_W-1:0] old_tag_0_i,
    input  logic             has_dest_1_i,
    input  logic [TAG_W-1:0] old_tag_1_i,
    output logic [1:0]       num_o,
    output logic [TAG_W-1:0] tag_0_o,
    output logic [TAG_W-1:0] tag_1_o
);

    logic free_0;
    logic free_1;

    assign free_0 = r0_i & has_dest_0_i;
    assign free_1 = r1_i & has_dest_1_i;

    always_comb begin
        num_o   = {1'b0, free_0} + {1'b0, free_1};
        tag_0_o = TAG_W'(TAG_NONE);
        tag_1_o = TAG_W'(TAG_NONE);
        if (free_0) begin
            tag_0_o = old_tag_0_i;
            if (free_1) begin
                tag_1_o = old_tag_1_i;
            end
        end else if (free_1) begin
            // Second entry slides down into lane 0 when the head had no dest.
            tag_0_o = old_tag_1_i;
        end
    end

endmodule

// File: rtl/prf_release_queue.sv
// In-order release queue returning stale physical tags to the free list.
// Define PRQ_CPL_BYPASS_EN to let a completion strobe retire its entry in the same cycle.
module prf_release_queue
    import prf_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int TAG_W = prf_pkg::TAG_W,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       dispatch_num,
    input  logic             dispatch_has_dest_0,
    input  logic             dispatch_has_dest_1,
    input  logic [TAG_W-1:0] dispatch_old_tag_0,
    input  logic [TAG_W-1:0] dispatch_old_tag_1,
    input  logic             complete_valid_0,
    input  logic             complete_valid_1,
    input  logic [IDX_W-1:0] complete_idx_0,
    input  logic [IDX_W-1:0] complete_idx_1,
    input  logic             recover,
    output logic [IDX_W-1:0] dispatch_idx_0,
    output logic [IDX_W-1:0] dispatch_idx_1,
    output logic [IDX_W:0]   free_slots,
    output logic             full,
    output logic             overflow_err,
    output logic [1:0]       rob_retire_num,
    output logic [TAG_W-1:0] rob_retire_tag_0,
    output logic [TAG_W-1:0] rob_retire_tag_1
);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || TAG_W != prf_pkg::TAG_W) begin : g_bad_cfg
        $error("prf_release_queue: DEPTH must be a power of 2 >= 4 and TAG_W must match prf_pkg");
    end

    localparam logic [IDX_W:0] DEPTH_C = (IDX_W + 1)'(DEPTH);

    prq_entry_t       entry_q [DEPTH];
    prq_entry_t       entry_d [DEPTH];
    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [IDX_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;

    logic [IDX_W-1:0] head_p1;
    logic [IDX_W-1:0] tail_p1;
    logic [1:0]       disp_n;
    logic             disp_fits;
    logic             disp_acc;
    logic             done_h0;
    logic             done_h1;
    logic             r0;
    logic             r1;

    assign head_p1 = head_q + IDX_W'(1);
    assign tail_p1 = tail_q + IDX_W'(1);

    assign free_slots     = DEPTH_C - count_q;
    assign full           = (free_slots < (IDX_W + 1)'(2));
    assign dispatch_idx_0 = tail_q;
    assign dispatch_idx_1 = tail_p1;
    assign overflow_err   = overflow_q;

    // dispatch_num == 3 is an illegal encoding and dispatches nothing.
    assign disp_n    = (dispatch_num == 2'd3) ? 2'd0 : dispatch_num;
    assign disp_fits = ((IDX_W + 1)'(disp_n) <= free_slots);
    assign disp_acc  = !recover && disp_fits;

`ifdef PRQ_CPL_BYPASS_EN
    assign done_h0 = entry_q[head_q].done
                   | (complete_valid_0 && (complete_idx_0 == head_q))
                   | (complete_valid_1 && (complete_idx_1 == head_q));
    assign done_h1 = entry_q[head_p1].done
                   | (complete_valid_0 && (complete_idx_0 == head_p1))
                   | (complete_valid_1 && (complete_idx_1 == head_p1));
`else
    assign done_h0 = entry_q[head_q].done;
    assign done_h1 = entry_q[head_p1].done;
`endif

    assign r0 = !recover && entry_q[head_q].valid && done_h0;
    assign r1 = r0 && entry_q[head_p1].valid && done_h1;

    prq_retire_compact #(
        .TAG_W (TAG_W)
    ) u_compact (
        .r0_i         (r0),
        .r1_i         (r1),
        .has_dest_0_i (entry_q[head_q].has_dest),
        .old_tag_0_i  (entry_q[head_q].old_tag),
        .has_dest_1_i (entry_q[head_p1].has_dest),
        .old_tag_1_i  (entry_q[head_p1].old_tag),
        .num_o        (rob_retire_num),
        .tag_0_o      (rob_retire_tag_0),
        .tag_1_o      (rob_retire_tag_1)
    );

    // Entry updates: completion first, then dispatch into free slots, then
    // retire clears so a completion racing its own retire cannot resurrect it.
    always_comb begin
        entry_d = entry_q;
        if (recover) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_d[i].valid = 1'b0;
                entry_d[i].done  = 1'b0;
            end
        end else begin
            if (complete_valid_0 && entry_q[complete_idx_0].valid) begin
                entry_d[complete_idx_0].done = 1'b1;
            end
            if (complete_valid_1 && entry_q[complete_idx_1].valid) begin
                entry_d[complete_idx_1].done = 1'b1;
            end
            if (disp_acc && disp_n != 2'd0) begin
                entry_d[tail_q] = '{valid: 1'b1, done: 1'b0,
                                    has_dest: dispatch_has_dest_0,
                                    old_tag: dispatch_old_tag_0};
            end
            if (disp_acc && disp_n == 2'd2) begin
                entry_d[tail_p1] = '{valid: 1'b1, done: 1'b0,
                                     has_dest: dispatch_has_dest_1,
                                     old_tag: dispatch_old_tag_1};
            end
            if (r0) begin
                entry_d[head_q].valid = 1'b0;
                entry_d[head_q].done  = 1'b0;
            end
            if (r1) begin
                entry_d[head_p1].valid = 1'b0;
                entry_d[head_p1].done  = 1'b0;
            end
        end
    end

    always_comb begin
        head_d     = head_q + IDX_W'(r0) + IDX_W'(r1);
        tail_d     = tail_q + (disp_acc ? IDX_W'(disp_n) : IDX_W'(0));
        count_d    = count_q + (disp_acc ? (IDX_W + 1)'(disp_n) : (IDX_W + 1)'(0))
                   - (IDX_W + 1)'(r0) - (IDX_W + 1)'(r1);
        overflow_d = overflow_q | (!recover && !disp_fits);
        if (recover) begin
            tail_d  = head_q;
            count_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Only valid/done need reset; tag payload is qualified by valid.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset) begin
                entry_q[i].valid <= 1'b0;
                entry_q[i].done  <= 1'b0;
            end else begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

endmodule
